// File: rtl/rgb_pwm_meter.sv
// rgb_pwm_meter: three independent PWM duty-cycle meters (R, G, B).
// Each channel synchronizes its input, measures period and high time between
// successive rising edges and reports duty as an integer percent 0..100 through
// a sequential restoring divider. A line that holds one level for PERIOD_MAX
// cycles is reported as 0 or 100 without using the divider.
// Optional build macro: PWM_METER_DEGLITCH_EN -- when defined, the level only
// follows the synchronized input after it has held a new value for 3 cycles.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no rising edge seen since reset/timeout; P is a timeout counter
// S_MEASURE | counting a period that began at the last rising edge
module rgb_pwm_meter #(
    parameter int PERIOD_MAX = 1023,
    parameter int CW         = $clog2(PERIOD_MAX + 1)
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       in_R,
    input  logic       in_G,
    input  logic       in_B,
    output logic [7:0] out_R,
    output logic [7:0] out_G,
    output logic [7:0] out_B,
    output logic       valid_R,
    output logic       valid_G,
    output logic       valid_B
);

    localparam int NW = CW + 7;
    localparam int SW = $clog2(NW + 1);
    localparam logic [CW-1:0] P_MAX     = CW'(PERIOD_MAX);
    localparam logic [NW-1:0] PCT_SCALE = NW'(100);
    localparam logic [SW-1:0] DIV_STEPS = SW'(NW);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    logic [2:0] pwm_in;
    logic [7:0] duty [3];
    logic [2:0] duty_valid;

    assign pwm_in  = {in_B, in_G, in_R};
    assign out_R   = duty[0];
    assign out_G   = duty[1];
    assign out_B   = duty[2];
    assign valid_R = duty_valid[0];
    assign valid_G = duty_valid[1];
    assign valid_B = duty_valid[2];

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        logic          sync_1;
        logic          sync_2;
        logic          lvl;
        logic          lvl_q;
        logic          rise;
        state_t        state_q;
        state_t        state_d;
        logic          report;
        logic          handoff;
        logic [CW-1:0] per_q;
        logic [CW-1:0] hi_q;
        logic          div_busy;
        logic [SW-1:0] div_cnt;
        logic [CW-1:0] div_den;
        logic [CW:0]   div_rem;
        logic [NW-1:0] div_quo;
        logic [CW+1:0] rem_sh;
        logic [CW+1:0] rem_diff;
        logic          rem_fits;
        logic [CW:0]   rem_nx;
        logic [NW-1:0] quo_nx;
        logic [NW-1:0] num;
        logic [7:0]    duty_q;
        logic          valid_q;

        // two-flop synchronizer for the asynchronous PWM line
        always_ff @(posedge clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                sync_1 <= 1'b0;
                sync_2 <= 1'b0;
            end else begin
                sync_1 <= pwm_in[ch];
                sync_2 <= sync_1;
            end
        end

`ifdef PWM_METER_DEGLITCH_EN
        logic sync_3;

        // level follows the input only once three successive samples agree;
        // sync_1 only gates the update, so if it resolves late the update
        // simply lands one cycle later
        always_ff @(posedge clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                sync_3 <= 1'b0;
                lvl    <= 1'b0;
            end else begin
                sync_3 <= sync_2;
                if ((sync_1 == sync_2) && (sync_2 == sync_3)) begin
                    lvl <= sync_2;
                end
            end
        end
`else
        assign lvl = sync_2;
`endif

        // previous level for rising-edge detection
        always_ff @(posedge clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                lvl_q <= 1'b0;
            end else begin
                lvl_q <= lvl;
            end
        end

        assign rise = lvl & ~lvl_q;

        // FSM state register
        always_ff @(posedge clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                state_q <= S_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // next state, divider handoff and static-report decision
        always_comb begin
            state_d = state_q;
            report  = 1'b0;
            handoff = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        state_d = S_MEASURE;
                    end else if (per_q == P_MAX) begin
                        report = 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (rise) begin
                        handoff = 1'b1;
                    end else if (per_q == P_MAX) begin
                        report  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // period and high-time counters; the edge cycle is cycle 1 of a period
        always_ff @(posedge clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                per_q <= '0;
                hi_q  <= '0;
            end else if (report) begin
                per_q <= '0;
                hi_q  <= '0;
            end else if (rise) begin
                per_q <= CW'(1);
                hi_q  <= CW'(1);
            end else begin
                per_q <= per_q + CW'(1);
                hi_q  <= hi_q + CW'(lvl);
            end
        end

        assign num      = NW'(hi_q) * PCT_SCALE;
        assign rem_sh   = {div_rem, div_quo[NW-1]};
        assign rem_diff = rem_sh - {2'b00, div_den};
        assign rem_fits = ~rem_diff[CW+1];
        assign rem_nx   = rem_fits ? rem_diff[CW:0] : rem_sh[CW:0];
        assign quo_nx   = {div_quo[NW-2:0], rem_fits};

        // restoring divider: one quotient bit per cycle; a pair that arrives
        // while busy is dropped, and a static report aborts the divide
        always_ff @(posedge clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                div_busy <= 1'b0;
                div_cnt  <= '0;
                div_den  <= '0;
                div_rem  <= '0;
                div_quo  <= '0;
            end else if (report) begin
                div_busy <= 1'b0;
                div_cnt  <= '0;
            end else if (handoff && !div_busy) begin
                div_busy <= 1'b1;
                div_cnt  <= DIV_STEPS;
                div_den  <= per_q;
                div_rem  <= '0;
                div_quo  <= num;
            end else if (div_busy) begin
                if (div_cnt != '0) begin
                    div_rem <= rem_nx;
                    div_quo <= quo_nx;
                    div_cnt <= div_cnt - SW'(1);
                end else begin
                    div_busy <= 1'b0;
                end
            end
        end

        // result register: static report wins over a divide finishing together
        always_ff @(posedge clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                duty_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= 1'b0;
                if (report) begin
                    duty_q  <= lvl ? 8'd100 : 8'd0;
                    valid_q <= 1'b1;
                end else if (div_busy && (div_cnt == SW'(1))) begin
                    duty_q  <= quo_nx[7:0];
                    valid_q <= 1'b1;
                end
            end
        end

        assign duty[ch]       = duty_q;
        assign duty_valid[ch] = valid_q;
    end

endmodule

// File: tb/tb_rgb_pwm_meter.sv
// tb_rgb_pwm_meter: randomized stimulus checked against a timestamp-based
// reference model of the duty meter (edges, timeouts and divider occupancy
// expressed as cycle numbers rather than counters).
module tb_rgb_pwm_meter;

    localparam int PMAX = 1023;
    localparam int LAT  = 18;
    localparam int NCYC = 20000;
`ifdef PWM_METER_DEGLITCH_EN
    localparam bit DG = 1'b1;
`else
    localparam bit DG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       in_R = 1'b0, in_G = 1'b0, in_B = 1'b0;
    logic [7:0] out_R, out_G, out_B;
    logic       valid_R, valid_G, valid_B;

    rgb_pwm_meter dut (
        .clk      (clk),
        .sys_rst_n(sys_rst_n),
        .in_R     (in_R),
        .in_G     (in_G),
        .in_B     (in_B),
        .out_R    (out_R),
        .out_G    (out_G),
        .out_B    (out_B),
        .valid_R  (valid_R),
        .valid_G  (valid_G),
        .valid_B  (valid_B)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    string nm [3]  = '{"R", "G", "B"};

    // model state
    bit ie [3][NCYC];
    bit lv [3][NCYC];
    int base [3], e_prev [3], busy_last [3], pt [3], pv [3], rt [3], rv [3];
    int exp_out [3];
    bit in_meas [3];
    int ov [3], oo [3];

    // stimulus state
    int smode [3], sper [3], shi [3], ph [3];
    bit slvl [3];
    bit rst_want = 1'b1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            exp_out[c]   = 0;
            pt[c]        = -1;
            rt[c]        = -1;
            in_meas[c]   = 1'b0;
            busy_last[c] = -100;
            e_prev[c]    = 0;
            base[c]      = cyc;
        end
    endtask

    task automatic model_cycle(input int c);
        int n, p, h, pp;
        bit ev, e;
        n = cyc;
        if (!sys_rst_n) begin
            lv[c][n] = 1'b0;
            check_val({"rst_valid_", nm[c]}, ov[c], 0);
            check_val({"rst_out_", nm[c]}, oo[c], 0);
            return;
        end
        ev = 1'b0;
        if (rt[c] == n) begin
            ev = 1'b1;
            exp_out[c] = rv[c];
        end else if (pt[c] == n) begin
            ev = 1'b1;
            exp_out[c] = pv[c];
        end
        if (pt[c] == n) pt[c] = -1;
        if (rt[c] == n) rt[c] = -1;
        if (ev || ov[c] != 0) check_val({"valid_", nm[c]}, ov[c], int'(ev));
        if (ev || (n % 97) == 0) check_val({"out_", nm[c]}, oo[c], exp_out[c]);

        // level seen by the meter, from the input history
        if (DG) begin
            if (n >= 4 && ie[c][n-2] == ie[c][n-3] && ie[c][n-3] == ie[c][n-4])
                lv[c][n] = ie[c][n-2];
            else
                lv[c][n] = (n >= 1) ? lv[c][n-1] : 1'b0;
        end else begin
            lv[c][n] = (n >= 2) ? ie[c][n-2] : 1'b0;
        end
        e = lv[c][n] && !lv[c][n-1];
        p = n - base[c];

        if (e) begin
            if (in_meas[c]) begin
                pp = n - e_prev[c];
                h  = 0;
                for (int k = e_prev[c]; k < n; k++) h += int'(lv[c][k]);
                if (n > busy_last[c]) begin
                    pt[c]        = n + LAT;
                    pv[c]        = (h * 100) / pp;
                    busy_last[c] = n + LAT;
                end
            end
            in_meas[c] = 1'b1;
            e_prev[c]  = n;
            base[c]    = n;
        end else if (p == PMAX) begin
            rt[c]        = n + 1;
            rv[c]        = lv[c][n] ? 100 : 0;
            in_meas[c]   = 1'b0;
            base[c]      = n + 1;
            busy_last[c] = n;
            if (pt[c] > n) pt[c] = -1;
        end
    endtask

    task automatic step();
        bit v [3];
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= NCYC - 1) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, NCYC - 1);
            $fatal(1, "cycle budget exhausted");
        end
        ov[0] = int'(valid_R); ov[1] = int'(valid_G); ov[2] = int'(valid_B);
        oo[0] = int'(out_R);   oo[1] = int'(out_G);   oo[2] = int'(out_B);
        for (int c = 0; c < 3; c++) model_cycle(c);

        if (rst_want && sys_rst_n) begin
            sys_rst_n = 1'b0;
            model_reset();
            #1;
            check_val("rst_async_out_R", int'(out_R), 0);
            check_val("rst_async_valid_R", int'(valid_R), 0);
            check_val("rst_async_out_B", int'(out_B), 0);
        end else if (!rst_want && !sys_rst_n) begin
            sys_rst_n = 1'b1;
            for (int c = 0; c < 3; c++) base[c] = cyc;
        end

        for (int c = 0; c < 3; c++) begin
            if (smode[c] == 0) begin
                v[c]  = (ph[c] < shi[c]);
                ph[c] = (ph[c] + 1) % sper[c];
            end else begin
                v[c] = slvl[c];
            end
            ie[c][cyc] = sys_rst_n ? v[c] : 1'b0;
        end
        in_R = v[0];
        in_G = v[1];
        in_B = v[2];
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_pwm(input int c, input int per, input int hi);
        smode[c] = 0;
        sper[c]  = per;
        shi[c]   = hi;
        ph[c]    = $urandom_range(0, per - 1);
    endtask

    task automatic set_const(input int c, input bit l);
        smode[c] = 1;
        slvl[c]  = l;
    endtask

    initial begin
        #(NCYC * 10 + 1000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int per, hi;
        bit found;
        model_reset();
        for (int c = 0; c < 3; c++) set_const(c, 1'b0);

        // reset held with toggling inputs, then release with inputs low
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < 3; c++) slvl[c] = 1'($urandom_range(0, 1));
            step();
        end
        for (int c = 0; c < 3; c++) slvl[c] = 1'b0;
        rst_want = 1'b0;
        run(1100);
        check_val("idle_out_R", int'(out_R), 0);

        // R 100/30, G constant high, B 40/10
        set_pwm(0, 100, 30);
        set_const(1, 1'b1);
        set_pwm(2, 40, 10);
        run(3000);
        check_val("duty_R_30", int'(out_R), 30);
        check_val("static_G_100", int'(out_G), 100);
        check_val("duty_B_25", int'(out_B), 25);

        // G low, B short period 7/3, R random
        set_const(1, 1'b0);
        set_pwm(2, 7, 3);
        set_pwm(0, $urandom_range(19, 300), 1);
        shi[0] = $urandom_range(1, sper[0] - 1);
        run(2500);
        check_val("static_G_0", int'(out_G), 0);
        check_val("duty_B_42", int'(out_B), 42);

        // random segments
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < 3; c++) begin
                if ($urandom_range(0, 3) == 0) per = $urandom_range(2, 18);
                else per = $urandom_range(19, 300);
                hi = $urandom_range(0, per);
                set_pwm(c, per, hi);
            end
            run(800);
        end

        // single-cycle glitches on an otherwise low R line
        set_const(0, 1'b0);
        set_const(1, 1'b0);
        set_const(2, 1'b1);
        run(1100);
        slvl[0] = 1'b1; step();
        slvl[0] = 1'b0; run(49);
        slvl[0] = 1'b1; step();
        slvl[0] = 1'b0; run(30);
        check_val("glitch_R", int'(out_R), DG ? 0 : 2);
        run(1100);
        check_val("glitch_R_static", int'(out_R), 0);

        // reset 5 cycles after a period-closing edge at 100/60
        set_pwm(0, 100, 60);
        run(300);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (in_meas[0] && cyc == e_prev[0] + 5) found = 1'b1;
        end
        check_val("rst_sync_found", int'(found), 1);
        rst_want = 1'b1;
        run(3);
        rst_want = 1'b0;
        run(300);
        check_val("post_rst_R_60", int'(out_R), 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
